iter_mult_acc_x2: RTL and testbench

- Sequential successor of the combinational x2 accumulate layer.
- An unsigned WIDTH_A x WIDTH_B multiplier that retires 2 multiplier bits per clock through one reusable layer.
- Handles operand and result transfer with valid/ready handshakes.
- Terminates early when the remaining multiplier bits are zero.
- Sits between operand FIFOs and the result datapath in the FASM multiplier flow.

---
 rtl/iter_mult_pkg.sv | 19 +
 rtl/iter_mult_acc_x2_step.sv | 21 ++
 rtl/iter_mult_acc_x2.sv | 123 ++++++++++++
 tb/tb_iter_mult_acc_x2.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/iter_mult_pkg.sv
// Shared types and sizing helpers for the iterative radix-4 multiplier (iter_mult_acc_x2).
package iter_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH_A = 8;
  localparam int unsigned DEF_WIDTH_B = 8;
  localparam int unsigned PROD_W      = DEF_WIDTH_A + DEF_WIDTH_B;

  // Width of the pair counter, which holds 0 .. WIDTH_B/2-1.
  function automatic int unsigned cnt_width(input int unsigned width_b);
    return (width_b / 2 > 1) ? $clog2(width_b / 2) : 1;
  endfunction

endpackage

// File: rtl/iter_mult_acc_x2_step.sv
// One radix-4 layer: acc_out = acc_in + (a * pair) << (2*cnt).
module mul_layer_x2_step #(
  parameter int unsigned WIDTH_A = 8,
  parameter int unsigned AW      = 16,
  parameter int unsigned CW      = 2
)(
  input  logic [WIDTH_A-1:0] a,
  input  logic [1:0]         pair,
  input  logic [CW-1:0]      cnt,
  input  logic [AW-1:0]      acc_in,
  output logic [AW-1:0]      acc_out
);

  logic [WIDTH_A+1:0] pp;

  always_comb begin
    pp      = {2'b00, a} * {{WIDTH_A{1'b0}}, pair};
    acc_out = acc_in + (AW'(pp) << {cnt, 1'b0});
  end

endmodule

// File: rtl/iter_mult_acc_x2.sv
// Sequential unsigned multiplier retiring two multiplier bits per clock with valid/ready handshakes.
// Optional multiply-accumulate mode: define ITER_MULT_MAC_EN.
module iter_mult_acc_x2
  import iter_mult_pkg::*;
#(
  parameter int unsigned WIDTH_A   = DEF_WIDTH_A,
  parameter int unsigned WIDTH_B   = DEF_WIDTH_B,
  parameter int unsigned ACC_WIDTH = 24,
`ifdef ITER_MULT_MAC_EN
  localparam int unsigned AW = ACC_WIDTH
`else
  localparam int unsigned AW = WIDTH_A + WIDTH_B
`endif
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_A-1:0] a,
  input  logic [WIDTH_B-1:0] b,
  input  logic               cin,
`ifdef ITER_MULT_MAC_EN
  input  logic               acc_clr,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [AW-1:0]      product,
  output logic               busy
);

  localparam int unsigned PAIRS = WIDTH_B / 2;
  localparam int unsigned CW    = cnt_width(WIDTH_B);

  if (WIDTH_A < 2 || WIDTH_B < 2 || (WIDTH_B % 2) != 0 || ACC_WIDTH < WIDTH_A + WIDTH_B)
  begin : g_param_check
    $error("iter_mult_acc_x2: illegal parameter combination");
  end

  state_t             state;
  logic [WIDTH_A-1:0] a_r;
  logic [WIDTH_B-1:0] b_sh;
  logic [CW-1:0]      cnt;
  logic [AW-1:0]      acc;
  logic [AW-1:0]      acc_step;
  logic [AW-1:0]      acc_init;
  logic               accept;
  logic               last_pair;

  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign product   = acc;
  assign last_pair = ((b_sh >> 2) == '0) || (cnt == CW'(PAIRS - 1));

`ifdef ITER_MULT_MAC_EN
  assign acc_init = acc_clr ? AW'(cin) : acc + AW'(cin);
`else
  assign acc_init = AW'(cin);
`endif

  mul_layer_x2_step #(
    .WIDTH_A (WIDTH_A),
    .AW      (AW),
    .CW      (CW)
  ) u_step (
    .a       (a_r),
    .pair    (b_sh[1:0]),
    .cnt     (cnt),
    .acc_in  (acc),
    .acc_out (acc_step)
  );

  // Accept is only possible from IDLE or DONE, so it takes priority over the state actions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_r       <= '0;
      b_sh      <= '0;
      cnt       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (accept) begin
      a_r  <= a;
      b_sh <= b;
      cnt  <= '0;
      acc  <= acc_init;
      if (b == '0) begin
        state     <= DONE;
        out_valid <= 1'b1;
        busy      <= 1'b0;
      end else begin
        state     <= RUN;
        out_valid <= 1'b0;
        busy      <= 1'b1;
      end
    end else begin
      case (state)
        RUN: begin
          acc  <= acc_step;
          b_sh <= b_sh >> 2;
          cnt  <= cnt + 1'b1;
          if (last_pair) begin
            state     <= DONE;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_mult_acc_x2.sv
// Self-checking bench for iter_mult_acc_x2 (WIDTH_A=WIDTH_B=8) against an arithmetic reference model.
module tb_iter_mult_acc_x2;

`ifdef ITER_MULT_MAC_EN
  localparam int unsigned PW = 24;
`else
  localparam int unsigned PW = iter_mult_pkg::PROD_W;
`endif

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    a;
  logic [7:0]    b;
  logic          cin;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] product;
  logic          busy;
`ifdef ITER_MULT_MAC_EN
  logic          acc_clr;
`endif

  int unsigned       total;
  int unsigned       bad;
  longint unsigned   model_acc;
  longint unsigned   exp_prod;
  int unsigned       exp_k;

  iter_mult_acc_x2 #(
    .WIDTH_A   (8),
    .WIDTH_B   (8),
    .ACC_WIDTH (24)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef ITER_MULT_MAC_EN
    .acc_clr   (acc_clr),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint unsigned obs, input longint unsigned expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Number of RUN cycles: ceil(bit length of b / 2).
  function automatic int unsigned run_cycles(input logic [7:0] v);
    int unsigned n = 0;
    for (int i = 0; i < 8; i++)
      if (v[i]) n = i + 1;
    return (n + 1) / 2;
  endfunction

  // Expected product for an accepted operation; tracks the accumulator in MAC builds.
  function automatic longint unsigned model(input logic [7:0] ta, input logic [7:0] tb_v,
                                            input logic tc, input logic tclr);
    longint unsigned mask = (64'd1 << PW) - 1;
    longint unsigned r    = longint'(ta) * longint'(tb_v) + longint'(tc);
`ifdef ITER_MULT_MAC_EN
    if (!tclr) r = r + model_acc;
`else
    if (tclr) r = r + 0;
`endif
    r = r & mask;
    model_acc = r;
    return r;
  endfunction

  task automatic drive_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                          input logic tclr);
    in_valid = 1'b1;
    a        = ta;
    b        = tb_v;
    cin      = tc;
`ifdef ITER_MULT_MAC_EN
    acc_clr  = tclr;
`endif
    exp_prod = model(ta, tb_v, tc, tclr);
    exp_k    = run_cycles(tb_v);
  endtask

  // Called just after the accept edge's following negedge; operands become don't-care.
  task automatic release_inputs();
    in_valid = 1'b0;
    a        = 8'($urandom);
    b        = 8'($urandom);
    cin      = 1'($urandom);
  endtask

  task automatic wait_result(input string tag);
    int unsigned runs  = 0;
    int unsigned guard = 0;
    while (out_valid !== 1'b1 && guard < 20) begin
      if (busy === 1'b1) runs++;
      @(negedge clk);
      guard++;
    end
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_runs"}, 64'(runs), 64'(exp_k));
    check({tag, "_prod"}, 64'(product), exp_prod);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic tc, input logic tclr, input int unsigned hold);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    out_ready = (hold == 0);
    drive_op(ta, tb_v, tc, tclr);
    @(negedge clk);
    release_inputs();
    wait_result(tag);
    for (int unsigned i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_prod"}, 64'(product), exp_prod);
      check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_drain"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    model_acc = 0;
    exp_prod  = 0;
    exp_k     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b1;
`ifdef ITER_MULT_MAC_EN
    acc_clr   = 1'b1;
`endif
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_product", 64'(product), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("max", 8'd255, 8'd255, 1'b1, 1'b1, 0);
    run_op("early", 8'd13, 8'd10, 1'b0, 1'b1, 0);
    run_op("bzero", 8'd200, 8'd0, 1'b1, 1'b1, 0);

    // Back-to-back: result held 5 cycles, then drained on the same edge as the next accept.
    out_ready = 1'b0;
    drive_op(8'd7, 8'd9, 1'b0, 1'b1);
    @(negedge clk);
    release_inputs();
    wait_result("b2b_first");
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      check("b2b_hold_prod", 64'(product), exp_prod);
      check("b2b_hold_in_ready", 64'(in_ready), 64'd0);
      check("b2b_hold_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    drive_op(8'd3, 8'd3, 1'b0, 1'b0);
    #1;
    check("b2b_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    release_inputs();
    check("b2b_gap_valid", 64'(out_valid), 64'd0);
    check("b2b_gap_busy", 64'(busy), 64'd1);
    wait_result("b2b_second");
    @(negedge clk);
    check("b2b_drain", 64'(out_valid), 64'd0);

    // Reset during RUN discards the partial product.
    drive_op(8'd100, 8'd200, 1'b0, 1'b1);
    @(negedge clk);
    release_inputs();
    @(negedge clk);
    check("mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_product", 64'(product), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    model_acc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post_rst", 8'd2, 8'd2, 1'b0, 1'b0, 0);

`ifdef ITER_MULT_MAC_EN
    run_op("mac0", 8'd10, 8'd10, 1'b0, 1'b1, 0);
    run_op("mac1", 8'd5, 8'd4, 1'b0, 1'b0, 0);
    run_op("mac2", 8'd1, 8'd1, 1'b0, 1'b0, 0);
    check("mac_total", model_acc, 64'd121);
`endif

    for (int i = 0; i < 24; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      run_op("rand", ra, rb, 1'($urandom), 1'($urandom), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
